mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the consecutive read grants allowed while a write-back waits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have l2_read  input  1  L2 line-fill request, held until l2_resp.
REQ-005 SHALL have l2_addr  input  12  line address of the fill.
REQ-006 SHALL have l2_rdata  output  128  fill data, valid when l2_resp=1.
REQ-007 SHALL have l2_resp  output  1  one-cycle fill-complete pulse.
REQ-008 SHALL have ewb_req  input  1  write buffer holds a dirty line awaiting drain.
REQ-009 SHALL have ewb_addr  input  12  line address of the buffered line.
REQ-010 SHALL have ewb_data  input  128  buffered line data.
REQ-011 SHALL have ewb_ack  output  1  one-cycle pulse: buffered line written to memory.
REQ-012 SHALL have pmem_read  output  1  memory read strobe.
REQ-013 SHALL have pmem_write  output  1  memory write strobe.
REQ-014 SHALL have pmem_address  output  16  byte address, {line_addr, 4'b0000}.
REQ-015 SHALL have pmem_wdata  output  128  write data.
REQ-016 SHALL have pmem_rdata  input  128  read data, valid with pmem_resp.
REQ-017 SHALL have pmem_resp  input  1  memory completion.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, FWD, GAP.
REQ-019 IDLE SHALL grant at most one request per cycle and latch its address (and data, for writes) into internal registers at grant.
REQ-020 IDLE SHALL go to FWD when l2_read=1, ewb_req=1, and l2_addr==ewb_addr; no memory access occurs.
REQ-021 Otherwise, IDLE SHALL go to READ when l2_read=1 and starve_cnt<STARVE_LIMIT.
REQ-022 Otherwise, IDLE SHALL go to WRITE when ewb_req=1.
REQ-023 IDLE SHALL stay in IDLE with no requests.
REQ-024 READ SHALL assert pmem_read with the latched address.
  - On pmem_resp: register pmem_rdata into l2_rdata, pulse l2_resp the next cycle, go to GAP.
REQ-025 WRITE SHALL assert pmem_write with the latched address and data.
  - On pmem_resp: pulse ewb_ack the next cycle, go to GAP.
REQ-026 FWD SHALL last one cycle and drive l2_rdata=latched ewb_data with l2_resp=1, then go to GAP; ewb_ack is not pulsed, so the line still drains later.
REQ-027 GAP SHALL last exactly one cycle with both strobes low, then return to IDLE; this lets requesters drop or refresh their requests.
REQ-028 l2_resp and ewb_ack SHALL each be high exactly one cycle per completed transaction and SHALL never be high together.
REQ-029 pmem_read and pmem_write SHALL never be high together, and SHALL be high only in READ or WRITE respectively.
REQ-030 starve_cnt (saturating, width ceil(log2(STARVE_LIMIT+1))) SHALL update on grant:
  - increments on a READ grant while ewb_req=1;
  - clears on a WRITE grant or when ewb_req=0 at grant;
  - is unchanged by FWD.
REQ-031 Once starve_cnt==STARVE_LIMIT with both requests pending (no address match), IDLE SHALL grant WRITE.
REQ-032 pmem_resp in IDLE, FWD or GAP SHALL be ignored.
REQ-033 A requester deasserting mid-transaction SHALL NOT abort it: the latched transaction completes and the response is still pulsed.
REQ-034 Fill latency SHALL be N+1 cycles from the READ grant edge to l2_resp, where N is memory response cycles; forward latency SHALL be 1 cycle.

Reset
REQ-035 On reset_n=0 the block SHALL immediately, without waiting for clk, enter IDLE and clear to 0: pmem_read, pmem_write, l2_resp, ewb_ack, l2_rdata, pmem_address, pmem_wdata, and starve_cnt.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no response pulse; the first grant SHALL occur on the first clk edge after reset_n rises.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
  - Fill: l2_read=1, l2_addr=0x123, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_address=0x1230, one l2_resp pulse carrying 0xA5..A5, then GAP.
  - Drain: ewb_req=1, ewb_addr=0x0FF, data=0xDEAD..BEEF -> pmem_write with pmem_address=0x0FF0 and that wdata; one ewb_ack pulse after pmem_resp.
  - Forward: l2_read=1 and ewb_req=1, both at address 0x040, data=0x1111.. -> l2_resp on the next cycle with 0x1111..; no strobe; the drain follows later.
  - Starvation: ewb_req held high, 5 back-to-back fills to distinct addresses -> grants are R,R,R,R,W,R.
  - Reset: reset_n pulled low during READ with pmem_read=1 -> pmem_read drops asynchronously, no l2_resp, IDLE after release.
  - Spurious: pmem_resp=1 while idle -> no outputs change.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single physical memory port between L2 line fills
// and write-buffer drains. Fills normally win, but a write-back that has been
// passed over STARVE_LIMIT times in a row is granted next. A fill that hits
// the line sitting in the write buffer is served straight from the buffer
// (forward) without touching memory; the buffered line still drains later.
//
// Ports
//   clk, reset_n                 single clock, async active-low reset
//   l2_read, l2_addr             fill request (held until l2_resp)
//   l2_rdata, l2_resp            fill data and one-cycle completion pulse
//   ewb_req, ewb_addr, ewb_data  write buffer dirty line awaiting drain
//   ewb_ack                      one-cycle pulse, line written to memory
//   pmem_read, pmem_write        memory strobes (never both high)
//   pmem_address, pmem_wdata     byte address {line, 4'b0000} and write data
//   pmem_rdata, pmem_resp        memory read data and completion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; latch address/data of the granted request
// READ  | pmem_read high until pmem_resp, then capture fill data
// WRITE | pmem_write high until pmem_resp
// FWD   | one cycle, l2_rdata comes from the write buffer, no memory access
// GAP   | one quiet cycle so requesters can drop or refresh requests
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         l2_read,
  input  logic [11:0]  l2_addr,
  output logic [127:0] l2_rdata,
  output logic         l2_resp,
  input  logic         ewb_req,
  input  logic [11:0]  ewb_addr,
  input  logic [127:0] ewb_data,
  output logic         ewb_ack,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FWD   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_fwd;
  logic             grant_read;
  logic             grant_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_fwd   = 1'b0;
    grant_read  = 1'b0;
    grant_write = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    case (state)
      IDLE: begin
        if (l2_read && ewb_req && (l2_addr == ewb_addr)) begin
          grant_fwd = 1'b1;
          state_nxt = FWD;
        end else if (l2_read && (!ewb_req || (starve_cnt < LIMIT))) begin
          // A saturated counter only blocks reads while a write is actually
          // waiting; with no write-back pending the fill must still proceed.
          grant_read = 1'b1;
          state_nxt  = READ;
        end else if (ewb_req) begin
          grant_write = 1'b1;
          state_nxt   = WRITE;
        end
      end
      READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_nxt = GAP;
      end
      WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) state_nxt = GAP;
      end
      FWD:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response pulses are registered: they default low every cycle and are set
  // only on the edge that completes a transaction, so each is one cycle wide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_rdata     <= '0;
      l2_resp      <= 1'b0;
      ewb_ack      <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      starve_cnt   <= '0;
    end else begin
      l2_resp <= 1'b0;
      ewb_ack <= 1'b0;

      if (grant_fwd) begin
        l2_rdata <= ewb_data;
        l2_resp  <= 1'b1;
      end

      if (grant_read) begin
        pmem_address <= {l2_addr, 4'b0000};
        if (!ewb_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end

      if (grant_write) begin
        pmem_address <= {ewb_addr, 4'b0000};
        pmem_wdata   <= ewb_data;
        starve_cnt   <= '0;
      end

      if ((state == READ) && pmem_resp) begin
        l2_rdata <= pmem_rdata;
        l2_resp  <= 1'b1;
      end

      if ((state == WRITE) && pmem_resp) begin
        ewb_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled 1 ns
// after the rising edge. Strobes are checked as one packed vector:
// {pmem_read, pmem_write, l2_resp, ewb_ack}.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         l2_read;
  logic [11:0]  l2_addr;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         ewb_req;
  logic [11:0]  ewb_addr;
  logic [127:0] ewb_data;
  logic         ewb_ack;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .l2_read      (l2_read),
    .l2_addr      (l2_addr),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .ewb_req      (ewb_req),
    .ewb_addr     (ewb_addr),
    .ewb_data     (ewb_data),
    .ewb_ack      (ewb_ack),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] strb();
    return {pmem_read, pmem_write, l2_resp, ewb_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    l2_read    = 1'b0;
    l2_addr    = '0;
    ewb_req    = 1'b0;
    ewb_addr   = '0;
    ewb_data   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    #2;
    total++;
    if (strb() !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", strb());
    else passed++;
    total++;
    if ({l2_rdata, pmem_address, pmem_wdata} !== '0)
      $display("FAIL reset_regs: rdata %h addr %h wdata %h want all 0", l2_rdata, pmem_address, pmem_wdata);
    else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL reset_idle: got %b want 0000", strb());
    else passed++;
  endtask

  task automatic test_fill();
    l2_read = 1'b1;
    l2_addr = 12'h123;
    tick();
    total++;
    if (strb() !== 4'b1000) $display("FAIL fill_grant: got %b want 1000", strb());
    else passed++;
    total++;
    if (pmem_address !== 16'h1230) $display("FAIL fill_addr: got %h want 1230", pmem_address);
    else passed++;
    tick();
    total++;
    if (strb() !== 4'b1000) $display("FAIL fill_wait: got %b want 1000", strb());
    else passed++;
    pmem_resp  = 1'b1;
    pmem_rdata = {16{8'hA5}};
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    total++;
    if (strb() !== 4'b0010) $display("FAIL fill_resp: got %b want 0010", strb());
    else passed++;
    total++;
    if (l2_rdata !== {16{8'hA5}}) $display("FAIL fill_data: got %h want a5..a5", l2_rdata);
    else passed++;
    l2_read = 1'b0;
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL fill_gap_end: got %b want 0000", strb());
    else passed++;
  endtask

  task automatic test_spurious();
    pmem_resp  = 1'b1;
    pmem_rdata = {4{32'h0BAD0BAD}};
    tick();
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL spur_strobes: got %b want 0000", strb());
    else passed++;
    total++;
    if (l2_rdata !== {16{8'hA5}} || pmem_address !== 16'h1230)
      $display("FAIL spur_hold: rdata %h addr %h want a5..a5 / 1230", l2_rdata, pmem_address);
    else passed++;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic test_drain();
    ewb_req  = 1'b1;
    ewb_addr = 12'h0FF;
    ewb_data = {4{32'hDEADBEEF}};
    tick();
    total++;
    if (strb() !== 4'b0100) $display("FAIL drain_grant: got %b want 0100", strb());
    else passed++;
    total++;
    if (pmem_address !== 16'h0FF0 || pmem_wdata !== {4{32'hDEADBEEF}})
      $display("FAIL drain_addr_data: addr %h wdata %h want 0ff0 / deadbeef x4", pmem_address, pmem_wdata);
    else passed++;
    // Requester drops mid-transaction; the latched write must still finish.
    ewb_req  = 1'b0;
    ewb_data = '0;
    tick();
    total++;
    if (strb() !== 4'b0100 || pmem_wdata !== {4{32'hDEADBEEF}})
      $display("FAIL drain_hold: strobes %b wdata %h want 0100 / deadbeef x4", strb(), pmem_wdata);
    else passed++;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    total++;
    if (strb() !== 4'b0001) $display("FAIL drain_ack: got %b want 0001", strb());
    else passed++;
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL drain_ack_width: got %b want 0000", strb());
    else passed++;
  endtask

  task automatic test_forward();
    l2_read  = 1'b1;
    l2_addr  = 12'h040;
    ewb_req  = 1'b1;
    ewb_addr = 12'h040;
    ewb_data = {8{16'h1111}};
    tick();
    total++;
    if (strb() !== 4'b0010) $display("FAIL fwd_resp: got %b want 0010", strb());
    else passed++;
    total++;
    if (l2_rdata !== {8{16'h1111}}) $display("FAIL fwd_data: got %h want 1111..", l2_rdata);
    else passed++;
    l2_read = 1'b0;
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL fwd_gap: got %b want 0000", strb());
    else passed++;
    tick();
    tick();
    total++;
    if (strb() !== 4'b0100 || pmem_address !== 16'h0400 || pmem_wdata !== {8{16'h1111}})
      $display("FAIL fwd_drain: strobes %b addr %h wdata %h want 0100 / 0400 / 1111..", strb(), pmem_address, pmem_wdata);
    else passed++;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    ewb_req   = 1'b0;
    total++;
    if (strb() !== 4'b0001) $display("FAIL fwd_drain_ack: got %b want 0001", strb());
    else passed++;
    tick();
  endtask

  task automatic test_starvation();
    bit          is_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          fill = 0;
    logic [3:0]  exp_s;
    logic [15:0] exp_a;
    ewb_req  = 1'b1;
    ewb_addr = 12'h0AA;
    ewb_data = {4{32'hCAFEF00D}};
    l2_read  = 1'b1;
    l2_addr  = 12'h200;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_s = is_w[i] ? 4'b0100 : 4'b1000;
      exp_a = is_w[i] ? 16'h0AA0 : {12'h200 + 12'(fill), 4'h0};
      total++;
      if (strb() !== exp_s || pmem_address !== exp_a)
        $display("FAIL starve_grant_%0d: strobes %b addr %h want %b / %h", i, strb(), pmem_address, exp_s, exp_a);
      else passed++;
      pmem_resp  = 1'b1;
      pmem_rdata = {4{32'h1000 + 32'(i)}};
      tick();
      pmem_resp  = 1'b0;
      exp_s = is_w[i] ? 4'b0001 : 4'b0010;
      total++;
      if (strb() !== exp_s) $display("FAIL starve_done_%0d: got %b want %b", i, strb(), exp_s);
      else passed++;
      if (!is_w[i]) begin
        fill++;
        l2_addr = 12'h200 + 12'(fill);
      end
      tick();
    end
    l2_read = 1'b0;
    ewb_req = 1'b0;
    tick();
    total++;
    if (strb() !== 4'b0000) $display("FAIL starve_idle: got %b want 0000", strb());
    else passed++;
  endtask

  task automatic test_reset_mid();
    l2_read = 1'b1;
    l2_addr = 12'h300;
    tick();
    total++;
    if (strb() !== 4'b1000) $display("FAIL rst_mid_grant: got %b want 1000", strb());
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (strb() !== 4'b0000) $display("FAIL rst_mid_async: got %b want 0000", strb());
    else passed++;
    total++;
    if (l2_rdata !== '0 || pmem_address !== 16'h0000 || pmem_wdata !== '0)
      $display("FAIL rst_mid_regs: rdata %h addr %h wdata %h want all 0", l2_rdata, pmem_address, pmem_wdata);
    else passed++;
    l2_read   = 1'b0;
    pmem_resp = 1'b1;
    tick();
    tick();
    pmem_resp = 1'b0;
    reset_n   = 1'b1;
    l2_read   = 1'b1;
    l2_addr   = 12'h301;
    total++;
    if (strb() !== 4'b0000) $display("FAIL rst_mid_no_resp: got %b want 0000", strb());
    else passed++;
    tick();
    total++;
    if (strb() !== 4'b1000 || pmem_address !== 16'h3010)
      $display("FAIL rst_first_grant: strobes %b addr %h want 1000 / 3010", strb(), pmem_address);
    else passed++;
    pmem_resp  = 1'b1;
    pmem_rdata = {2{64'h0123456789ABCDEF}};
    tick();
    pmem_resp = 1'b0;
    l2_read   = 1'b0;
    total++;
    if (strb() !== 4'b0010 || l2_rdata !== {2{64'h0123456789ABCDEF}})
      $display("FAIL rst_fill_resp: strobes %b rdata %h want 0010 / 0123..cdef", strb(), l2_rdata);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_spurious();
    test_drain();
    test_forward();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
